// File: rtl/cam_alloc.sv
// cam_alloc: slot allocator and controller for an external 8-entry CAM.
//
// Keeps a valid bit per CAM slot and serves insert/delete requests one at a time.
// On reset the CAM is scrubbed so that slot i holds key i. After the scrub, every
// lookup is qualified by the slot's valid bit. An insert reuses a stale copy of the
// key if one exists, so a key is never present in two slots. Otherwise the insert
// takes the lowest free slot. When all slots are full, it evicts the slot named by
// a round-robin pointer.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_key and req_del are sampled on accept
//   resp_valid/resp_ready response handshake; resp_* are held stable until consumed
//   resp_addr             slot that was written, matched or freed
//   resp_dup              insert found the key already valid
//   resp_evict            insert overwrote a valid slot
//   resp_miss             delete found no valid match
//   occupancy             popcount of the valid vector
//   cam_key/cam_we/cam_waddr  CAM write/search port
//   cam_hit/cam_raddr     combinational CAM match (highest matching index)
module cam_alloc (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_key,
  input  logic       req_del,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [2:0] resp_addr,
  output logic       resp_dup,
  output logic       resp_evict,
  output logic       resp_miss,
  output logic [3:0] occupancy,
  output logic [7:0] cam_key,
  output logic       cam_we,
  output logic [2:0] cam_waddr,
  input  logic       cam_hit,
  input  logic [2:0] cam_raddr
);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLook,
    StWrite,
    StResp
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] init_cnt_q, init_cnt_d;
  logic [7:0] valid_q, valid_d;
  logic [2:0] rr_q, rr_d;
  logic [7:0] key_q, key_d;
  logic       del_q, del_d;
  logic [2:0] target_q, target_d;
  logic [2:0] resp_addr_q, resp_addr_d;
  logic       dup_q, dup_d;
  logic       evict_q, evict_d;
  logic       miss_q, miss_d;

  logic       vhit;
  logic       free_found;
  logic [2:0] free_idx;

  // The CAM may still hold keys of freed slots, so a raw hit counts only if the slot is valid.
  assign vhit = cam_hit & valid_q[cam_raddr];

  // Lowest-index free slot. The loop scans downward so the lowest index is assigned last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    key_d       = key_q;
    del_d       = del_q;
    target_d    = target_q;
    resp_addr_d = resp_addr_q;
    dup_d       = dup_q;
    evict_d     = evict_q;
    miss_d      = miss_q;

    case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 3'd1;
        if (init_cnt_q == 3'd7) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (req_valid) begin
          key_d       = req_key;
          del_d       = req_del;
          resp_addr_d = 3'd0;
          dup_d       = 1'b0;
          evict_d     = 1'b0;
          miss_d      = 1'b0;
          state_d     = StLook;
        end
      end

      StLook: begin
        if (del_q) begin
          if (vhit) begin
            valid_d[cam_raddr] = 1'b0;
            resp_addr_d        = cam_raddr;
          end else begin
            miss_d      = 1'b1;
            resp_addr_d = 3'd0;
          end
          state_d = StResp;
        end else if (vhit) begin
          dup_d       = 1'b1;
          resp_addr_d = cam_raddr;
          state_d     = StResp;
        end else begin
          if (cam_hit) begin
            // A stale copy exists; overwrite that copy so the key never appears twice.
            target_d = cam_raddr;
          end else if (free_found) begin
            target_d = free_idx;
          end else begin
            target_d = rr_q;
            evict_d  = 1'b1;
            rr_d     = rr_q + 3'd1;
          end
          state_d = StWrite;
        end
      end

      StWrite: begin
        valid_d[target_q] = 1'b1;
        resp_addr_d       = target_q;
        state_d           = StResp;
      end

      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      init_cnt_q  <= 3'd0;
      valid_q     <= 8'd0;
      rr_q        <= 3'd0;
      key_q       <= 8'd0;
      del_q       <= 1'b0;
      target_q    <= 3'd0;
      resp_addr_q <= 3'd0;
      dup_q       <= 1'b0;
      evict_q     <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      key_q       <= key_d;
      del_q       <= del_d;
      target_q    <= target_d;
      resp_addr_q <= resp_addr_d;
      dup_q       <= dup_d;
      evict_q     <= evict_d;
      miss_q      <= miss_d;
    end
  end

  always_comb begin
    occupancy = 4'd0;
    for (int i = 0; i < 8; i++) begin
      occupancy = occupancy + 4'(valid_q[i]);
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_addr  = resp_addr_q;
    resp_dup   = dup_q;
    resp_evict = evict_q;
    resp_miss  = miss_q;
    cam_we     = 1'b0;
    cam_waddr  = 3'd0;
    cam_key    = key_q;
    if (state_q == StInit) begin
      cam_we    = 1'b1;
      cam_waddr = init_cnt_q;
      cam_key   = {5'd0, init_cnt_q};
    end else if (state_q == StWrite) begin
      cam_we    = 1'b1;
      cam_waddr = target_q;
    end
  end

endmodule

// File: tb/tb_cam_alloc.sv
// Bench for cam_alloc: behavioural CAM environment, reference allocator model and
// response scoreboard.
module tb_cam_alloc;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_key;
  logic       req_del;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_addr;
  logic       resp_dup;
  logic       resp_evict;
  logic       resp_miss;
  logic [3:0] occupancy;
  logic [7:0] cam_key;
  logic       cam_we;
  logic [2:0] cam_waddr;
  logic       cam_hit;
  logic [2:0] cam_raddr;

  cam_alloc dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_del    (req_del),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_dup   (resp_dup),
    .resp_evict (resp_evict),
    .resp_miss  (resp_miss),
    .occupancy  (occupancy),
    .cam_key    (cam_key),
    .cam_we     (cam_we),
    .cam_waddr  (cam_waddr),
    .cam_hit    (cam_hit),
    .cam_raddr  (cam_raddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CAM environment: registered write, combinational search, highest index wins.
  logic [7:0] cam_mem [8];
  always @(posedge clk) begin
    if (cam_we) cam_mem[cam_waddr] <= cam_key;
  end
  always_comb begin
    cam_hit   = 1'b0;
    cam_raddr = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cam_mem[i] == cam_key) begin
        cam_hit   = 1'b1;
        cam_raddr = 3'(i);
      end
    end
  end

  int we_cnt;
  always @(negedge clk) begin
    if (!rst && cam_we) we_cnt++;
  end

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {
    logic [2:0] addr;
    logic       dup;
    logic       evict;
    logic       miss;
    logic [3:0] occ;
    logic [1:0] lat;
    logic [1:0] we;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_key [8];
  logic [7:0] m_valid;
  logic [2:0] m_rr;
  int         we0;

  task automatic model_init();
    for (int i = 0; i < 8; i++) m_key[i] = 8'(i);
    m_valid = 8'd0;
    m_rr    = 3'd0;
    sb.delete();
  endtask

  function automatic exp_t model_req(input logic [7:0] k, input logic del);
    exp_t       e;
    logic       hit;
    logic [2:0] idx;
    logic       found;
    logic [2:0] fidx;
    e   = '0;
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m_key[i] == k) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
    if (del) begin
      e.lat = 2'd1;
      if (hit && m_valid[idx]) begin
        m_valid[idx] = 1'b0;
        e.addr       = idx;
      end else begin
        e.miss = 1'b1;
      end
    end else if (hit && m_valid[idx]) begin
      e.dup  = 1'b1;
      e.addr = idx;
      e.lat  = 2'd1;
    end else begin
      e.lat = 2'd2;
      e.we  = 2'd1;
      if (hit) begin
        e.addr = idx;
      end else begin
        found = 1'b0;
        fidx  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
          if (!m_valid[i]) begin
            found = 1'b1;
            fidx  = 3'(i);
          end
        end
        if (found) begin
          e.addr = fidx;
        end else begin
          e.addr  = m_rr;
          e.evict = 1'b1;
          m_rr    = m_rr + 3'd1;
        end
      end
      m_key[e.addr]   = k;
      m_valid[e.addr] = 1'b1;
    end
    e.occ = 4'($countones(m_valid));
    return e;
  endfunction

  // Called #1 after a rising edge with rst just deasserted; walks the scrub.
  task automatic check_init();
    for (int i = 0; i < 8; i++) begin
      check("init_we", 32'(cam_we), 32'd1);
      check("init_waddr", 32'(cam_waddr), 32'(i));
      check("init_key", 32'(cam_key), 32'(i));
      check("init_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_occ", 32'(occupancy), 32'd0);
    check("idle_we", 32'(cam_we), 32'd0);
  endtask

  task automatic start_req(input logic [7:0] k, input logic del);
    exp_t e;
    int   cyc;
    e = model_req(k, del);
    sb.push_back(e);
    we0       = we_cnt;
    req_key   = k;
    req_del   = del;
    req_valid = 1'b1;
    cyc       = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc       = 0;
    while (!resp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(e.lat));
  endtask

  task automatic finish_resp(input int hold);
    exp_t e;
    e = sb.pop_front();
    resp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_addr", 32'(resp_addr), 32'(e.addr));
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_addr", 32'(resp_addr), 32'(e.addr));
    check("resp_dup", 32'(resp_dup), 32'(e.dup));
    check("resp_evict", 32'(resp_evict), 32'(e.evict));
    check("resp_miss", 32'(resp_miss), 32'(e.miss));
    check("occupancy", 32'(occupancy), 32'(e.occ));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_done", 32'(resp_valid), 32'd0);
    check("cam_writes", 32'(we_cnt - we0), 32'(e.we));
  endtask

  task automatic do_req(input logic [7:0] k, input logic del, input int hold);
    start_req(k, del);
    finish_resp(hold);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    we_cnt     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_key    = 8'd0;
    req_del    = 1'b0;
    resp_ready = 1'b0;
    model_init();

    @(posedge clk); #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_init();

    // Stale reuse, then lowest free slot, then duplicate.
    do_req(8'h03, 1'b0, 0);
    do_req(8'hA5, 1'b0, 0);
    do_req(8'hA5, 1'b0, 1);

    // Fill remaining slots, then evict round-robin through a full wrap.
    for (int i = 0; i < 6; i++) do_req(8'(8'h10 + i), 1'b0, 0);
    do_req(8'h77, 1'b0, 0);
    for (int i = 0; i < 8; i++) do_req(8'(8'h80 + i), 1'b0, 0);

    // Miss, delete of slot 5 (holds 0x84), refill into slot 5 with a held response.
    do_req(8'hEE, 1'b1, 0);
    do_req(8'h84, 1'b1, 0);
    do_req(8'h99, 1'b0, 3);

    // Reset while a response is waiting.
    start_req(8'h42, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_occ", 32'(occupancy), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    check("rst_mid_waddr", 32'(cam_waddr), 32'd0);
    model_init();
    @(posedge clk); #1;
    rst = 1'b0;
    check_init();
    do_req(8'h03, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_alloc.md
CAM_ALLOC -- requirements
Module: cam_alloc

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL have exactly these ports:
- clk  in  1  clock; all registers on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid & req_ready at a clk edge.
- req_key  in  8  key to insert or delete.
- req_del  in  1  1 = delete, 0 = insert; sampled with req_key.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready at a clk edge.
- resp_addr  out  3  slot written, matched, or freed.
- resp_dup  out  1  insert found the key already valid.
- resp_evict  out  1  insert overwrote a valid slot.
- resp_miss  out  1  delete found no valid match.
- occupancy  out  4  number of valid slots, 0..8.
- cam_key  out  8  key presented to the 8-entry CAM write/search port.
- cam_we  out  1  CAM write enable.
- cam_waddr  out  3  CAM write slot.
- cam_hit  in  1  combinational CAM match flag for cam_key.
- cam_raddr  in  3  combinational CAM match slot; highest matching index.

Function
REQ-003 The block SHALL hold an 8-bit valid vector, a 3-bit round-robin victim pointer rr, and a latched key/op register.
REQ-004 The FSM SHALL have the states INIT, IDLE, LOOK, WRITE and RESP.
REQ-005 INIT SHALL run for 8 cycles with cam_we=1, cam_waddr=i and cam_key=i for i=0..7, then go to IDLE; req_ready=0 throughout.
REQ-006 req_ready SHALL be 1 only in IDLE; on accept the key/op SHALL be latched and the FSM SHALL go to LOOK.
REQ-007 Outside INIT, cam_key SHALL equal the latched key; the match SHALL be qualified as vhit = cam_hit & valid[cam_raddr].
REQ-008 In LOOK, an insert with vhit SHALL go to RESP with resp_dup=1, resp_addr=cam_raddr and no write.
REQ-009 In LOOK, an insert with cam_hit & !vhit SHALL target cam_raddr, reusing the stale copy so that no key is ever present in two slots.
REQ-010 In LOOK, an insert with no cam_hit SHALL target the lowest-index invalid slot.
- If all 8 slots are valid, it SHALL target rr, set resp_evict=1, and advance rr by 1 mod 8 (7 wraps to 0).
REQ-011 WRITE SHALL last one cycle with cam_we=1 and cam_waddr=target, SHALL set valid[target], then go to RESP with resp_addr=target.
REQ-012 In LOOK, a delete with vhit SHALL clear valid[cam_raddr] with no CAM write and go to RESP with resp_addr=cam_raddr.
- A delete without vhit SHALL go to RESP with resp_miss=1 and resp_addr=0.
REQ-013 In RESP, resp_valid=1 and all resp_* SHALL hold stable until resp_ready; then go to IDLE.
- A response of resp_valid with resp_ready already high SHALL complete in one cycle.
REQ-014 cam_we SHALL be 0 in every state except INIT and WRITE.
REQ-015 Latency from accept edge to resp_valid SHALL be 2 cycles for new or reused inserts and 1 cycle for dup, delete and miss.
REQ-016 occupancy SHALL equal the popcount of the valid vector at all times.
- An evict SHALL leave occupancy at 8.

Reset
REQ-017 On rst assertion, asynchronously and in any state, the block SHALL enter INIT and clear valid to 0, rr to 0, and occupancy to 0.
- It SHALL also drive resp_valid, resp_dup, resp_evict, resp_miss, resp_addr, req_ready and cam_waddr to 0.
- Any in-flight request SHALL be dropped.
REQ-018 After rst deasserts, INIT SHALL restart from i=0.

Verification
REQ-019 Reset then idle -> 8 cycles of cam_we with waddr 0..7, then req_ready=1 and occupancy=0.
REQ-020 Insert 0x03 after INIT -> stale hit at slot 3 is reused; resp_addr=3, dup=0, evict=0, occupancy=1. Then insert 0xA5 -> resp_addr=0.
REQ-021 Insert 0xA5 again -> resp_dup=1, resp_addr=0, no cam_we, occupancy unchanged.
REQ-022 Fill 8 distinct keys, then insert 0x77 -> resp_evict=1, resp_addr=0, rr=1. Eight further new inserts -> addresses 1..7 then 0 (wrap).
REQ-023 Delete an absent key -> resp_miss=1. Delete a present key at slot 5 -> resp_addr=5, occupancy decrements by 1, and a next new insert lands in slot 5.
REQ-024 Assert rst while in RESP with resp_ready=0 -> resp_valid drops immediately, occupancy=0, and INIT restarts.
